// File: rtl/matrix_element_writer.sv
// Registered M x N matrix updated by element, row, column or serial stream.
// Flattened output packs A[0][0] in the top nBits, row-major downward.
module matrix_element_writer #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int nBits = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   valid,
  output logic                   ready,
  input  logic [1:0]             op,
  input  logic [nBits-1:0]       ipos,
  input  logic [nBits-1:0]       jpos,
  input  logic [nBits-1:0]       rowsel,
  input  logic [nBits-1:0]       coloumnsel,
  input  logic [nBits-1:0]       element,
  input  logic [nBits*N-1:0]     row,
  input  logic [nBits*M-1:0]     coloumn,
  input  logic [nBits-1:0]       stream_in,
  input  logic                   stream_valid,
  output logic [nBits*M*N-1:0]   matrix,
  output logic                   done,
  output logic                   err
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  localparam logic [nBits-1:0] MLIM = nBits'(M);
  localparam logic [nBits-1:0] NLIM = nBits'(N);

  logic [0:0]           state, state_n;
  logic [RW-1:0]        r, r_n;
  logic [CW-1:0]        c, c_n;
  logic [nBits*M*N-1:0] mat_n;
  logic                 done_n, err_n;

  assign ready = (state == IDLE);

  always_comb begin
    mat_n   = matrix;
    state_n = state;
    r_n     = r;
    c_n     = c;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (clear) begin
      mat_n   = '0;
      state_n = IDLE;
      r_n     = '0;
      c_n     = '0;
    end else if (state == IDLE) begin
      if (valid) begin
        unique case (op)
          2'b00: begin
            if (ipos < MLIM && jpos < NLIM) begin
              for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                  if (ipos == nBits'(i) && jpos == nBits'(j))
                    mat_n[(M*N-1-(N*i+j))*nBits +: nBits] = element;
                end
              end
              done_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          2'b01: begin
            if (rowsel < MLIM) begin
              for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                  if (rowsel == nBits'(i))
                    mat_n[(M*N-1-(N*i+j))*nBits +: nBits] =
                      row[(N-1-j)*nBits +: nBits];
                end
              end
              done_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          2'b10: begin
            if (coloumnsel < NLIM) begin
              for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                  if (coloumnsel == nBits'(j))
                    mat_n[(M*N-1-(N*i+j))*nBits +: nBits] =
                      coloumn[(M-1-i)*nBits +: nBits];
                end
              end
              done_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          default: begin
            state_n = LOAD;
            r_n     = '0;
            c_n     = '0;
          end
        endcase
      end
    end else if (stream_valid) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          if (r == RW'(i) && c == CW'(j))
            mat_n[(M*N-1-(N*i+j))*nBits +: nBits] = stream_in;
        end
      end
      // Row-major walk; the last beat closes the stream.
      if (c == CW'(N-1)) begin
        c_n = '0;
        if (r == RW'(M-1)) begin
          r_n     = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          r_n = r + RW'(1);
        end
      end else begin
        c_n = c + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix <= '0;
      state  <= IDLE;
      r      <= '0;
      c      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      matrix <= mat_n;
      state  <= state_n;
      r      <= r_n;
      c      <= c_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_matrix_element_writer.sv
// Bench for matrix_element_writer at M=2, N=3, nBits=8.
// Table vectors, scripted corner sequences and a random run against a model.
module tb_matrix_element_writer;

  localparam int M = 2;
  localparam int N = 3;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear = 1'b0;
  logic            valid = 1'b0;
  logic            ready;
  logic [1:0]      op = 2'b00;
  logic [W-1:0]    ipos = '0;
  logic [W-1:0]    jpos = '0;
  logic [W-1:0]    rowsel = '0;
  logic [W-1:0]    coloumnsel = '0;
  logic [W-1:0]    element = '0;
  logic [W*N-1:0]  row = '0;
  logic [W*M-1:0]  coloumn = '0;
  logic [W-1:0]    stream_in = '0;
  logic            stream_valid = 1'b0;
  logic [W*M*N-1:0] matrix;
  logic            done;
  logic            err;

  matrix_element_writer #(.M(M), .N(N), .nBits(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid),
    .ready(ready), .op(op), .ipos(ipos), .jpos(jpos),
    .rowsel(rowsel), .coloumnsel(coloumnsel),
    .element(element), .row(row), .coloumn(coloumn),
    .stream_in(stream_in), .stream_valid(stream_valid),
    .matrix(matrix), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: plain 2-D array plus a beat count
  logic [W-1:0] ma [M][N];
  bit           in_load;
  int           k;
  bit           e_done;
  bit           e_err;

  function automatic logic [47:0] pack();
    logic [47:0] res;
    res = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        res[(M*N-1-(N*i+j))*W +: W] = ma[i][j];
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        ma[i][j] = '0;
    in_load = 0;
    k = 0;
    e_done = 0;
    e_err = 0;
  endtask

  task automatic model_step();
    int ri;
    int ci;
    e_done = 0;
    e_err = 0;
    if (clear) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          ma[i][j] = '0;
      in_load = 0;
      k = 0;
    end else if (!in_load) begin
      if (valid) begin
        case (op)
          2'd0: if (int'(ipos) < M && int'(jpos) < N) begin
            ma[int'(ipos)][int'(jpos)] = element;
            e_done = 1;
          end else e_err = 1;
          2'd1: if (int'(rowsel) < M) begin
            for (int j = 0; j < N; j++)
              ma[int'(rowsel)][j] = row[(N-1-j)*W +: W];
            e_done = 1;
          end else e_err = 1;
          2'd2: if (int'(coloumnsel) < N) begin
            for (int i = 0; i < M; i++)
              ma[i][int'(coloumnsel)] = coloumn[(M-1-i)*W +: W];
            e_done = 1;
          end else e_err = 1;
          default: begin
            in_load = 1;
            k = 0;
          end
        endcase
      end
    end else if (stream_valid) begin
      ri = k / N;
      ci = k % N;
      ma[ri][ci] = stream_in;
      k++;
      if (k == M*N) begin
        in_load = 0;
        k = 0;
        e_done = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cycle(input string nm);
    model_step();
    @(posedge clk);
    #1;
    chk({nm, " matrix"}, matrix, pack());
    chk({nm, " done"}, 48'(done), 48'(e_done));
    chk({nm, " err"}, 48'(err), 48'(e_err));
    chk({nm, " ready"}, 48'(ready), 48'(!in_load));
  endtask

  task automatic idle_in();
    valid = 0;
    clear = 0;
    stream_valid = 0;
  endtask

  task automatic beat(input logic [7:0] d, input string nm);
    idle_in();
    stream_valid = 1;
    stream_in = d;
    cycle(nm);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  el;
    logic [23:0] rw;
    logic [15:0] cl;
    logic [47:0] exp_m;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{2'd1, 8'd0, 8'd0, 8'h00, 24'h112233, 16'h0,
               48'h112233000000, 1'b1, 1'b0};
    tbl[1] = '{2'd2, 8'd1, 8'd0, 8'h00, 24'h0, 16'h5566,
               48'h115533006600, 1'b1, 1'b0};
    tbl[2] = '{2'd0, 8'd1, 8'd2, 8'hAB, 24'h0, 16'h0,
               48'h1155330066AB, 1'b1, 1'b0};
    tbl[3] = '{2'd0, 8'd2, 8'd0, 8'hFF, 24'h0, 16'h0,
               48'h1155330066AB, 1'b0, 1'b1};
    tbl[4] = '{2'd2, 8'd3, 8'd0, 8'h00, 24'h0, 16'hFFFF,
               48'h1155330066AB, 1'b0, 1'b1};
    tbl[5] = '{2'd1, 8'd2, 8'd0, 8'h00, 24'hFFFFFF, 16'h0,
               48'h1155330066AB, 1'b0, 1'b1};
    tbl[6] = '{2'd0, 8'd0, 8'd3, 8'hFF, 24'h0, 16'h0,
               48'h1155330066AB, 1'b0, 1'b1};
    tbl[7] = '{2'd0, 8'h80, 8'd0, 8'hFF, 24'h0, 16'h0,
               48'h1155330066AB, 1'b0, 1'b1};
    tbl[8] = '{2'd1, 8'd1, 8'd0, 8'h00, 24'hAABBCC, 16'h0,
               48'h115533AABBCC, 1'b1, 1'b0};
    tbl[9] = '{2'd0, 8'd0, 8'd0, 8'hEE, 24'h0, 16'h0,
               48'hEE5533AABBCC, 1'b1, 1'b0};

    model_reset();
    #12;
    chk("rst matrix", matrix, 48'h0);
    chk("rst ready", 48'(ready), 48'h1);
    chk("rst done", 48'(done), 48'h0);
    chk("rst err", 48'(err), 48'h0);
    rst = 0;

    idle_in();
    valid = 1;
    op = 2'd0;
    ipos = 8'd1;
    jpos = 8'd2;
    element = 8'hAB;
    cycle("elem");
    chk("elem abs", matrix, 48'h0000000000AB);
    idle_in();
    cycle("elem gap");

    clear = 1;
    cycle("clear0");
    idle_in();

    // Back-to-back table commands, one per cycle
    for (int v = 0; v < 10; v++) begin
      valid = 1;
      op = tbl[v].op;
      ipos = tbl[v].a;
      jpos = tbl[v].b;
      rowsel = tbl[v].a;
      coloumnsel = tbl[v].a;
      element = tbl[v].el;
      row = tbl[v].rw;
      coloumn = tbl[v].cl;
      cycle($sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d m", v), matrix, tbl[v].exp_m);
      chk($sformatf("tbl%0d d", v), 48'(done), 48'(tbl[v].exp_done));
      chk($sformatf("tbl%0d e", v), 48'(err), 48'(tbl[v].exp_err));
    end
    idle_in();

    // Stream with a stall between beats 3 and 4
    valid = 1;
    op = 2'd3;
    cycle("ld start");
    beat(8'h01, "s1");
    beat(8'h02, "s2");
    beat(8'h03, "s3");
    idle_in();
    valid = 1;
    op = 2'd0;
    cycle("s stall");
    beat(8'h04, "s4");
    beat(8'h05, "s5");
    beat(8'h06, "s6");
    chk("stream m", matrix, 48'h010203040506);
    chk("stream done", 48'(done), 48'h1);
    chk("stream ready", 48'(ready), 48'h1);
    idle_in();
    stream_valid = 1;
    cycle("s idle beat");

    // Async reset mid-stream
    idle_in();
    valid = 1;
    op = 2'd3;
    cycle("ld2");
    beat(8'h01, "r1");
    beat(8'h02, "r2");
    beat(8'h03, "r3");
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("arst matrix", matrix, 48'h0);
    chk("arst ready", 48'(ready), 48'h1);
    #10;
    rst = 0;
    for (int n = 0; n < 3; n++) beat(8'h55, "post rst");
    chk("post rst m", matrix, 48'h0);

    // Clear during LOAD drops the concurrent beat
    idle_in();
    valid = 1;
    op = 2'd3;
    cycle("ld3");
    beat(8'h11, "c1");
    beat(8'h22, "c2");
    clear = 1;
    stream_valid = 1;
    stream_in = 8'h77;
    cycle("clr load");
    chk("clr m", matrix, 48'h0);
    chk("clr done", 48'(done), 48'h0);
    idle_in();
    valid = 1;
    op = 2'd3;
    cycle("ld4");
    beat(8'h99, "restart");
    chk("restart m", matrix, 48'h990000000000);

    // Randomised run
    for (int n = 0; n < 400; n++) begin
      clear = ($urandom_range(0, 24) == 0);
      valid = $urandom_range(0, 1) == 1;
      op = 2'($urandom_range(0, 3));
      ipos = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                         : 8'($urandom_range(0, 2));
      jpos = 8'($urandom_range(0, 3));
      rowsel = 8'($urandom_range(0, 2));
      coloumnsel = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                               : 8'($urandom_range(0, 3));
      element = 8'($urandom);
      row = 24'($urandom);
      coloumn = 16'($urandom);
      stream_in = 8'($urandom);
      stream_valid = $urandom_range(0, 1) == 1;
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/matrix_element_writer.md
Name: matrix_element_writer

Overview:
- Writer counterpart of the matrix element/row/column selector. It owns a registered M x N matrix and updates it one element, one full row, one full column, or a whole serial row-major stream at a time.
- Its flattened output uses the same packing the selector reads, so it can drive a selector directly.
- Sits ahead of the pseudo-inverse datapath to build or patch operand matrices.

Parameters:
- M, 4, number of rows
- N, 4, number of columns
- nBits, 32, bits per element

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous zero of matrix, aborts any stream
- valid  in  1  command request
- ready  out  1  writer accepts a command
- op  in  2  command: 00 element, 01 row, 10 coloumn, 11 stream load
- ipos  in  nBits  element row index
- jpos  in  nBits  element column index
- rowsel  in  nBits  row index for op 01
- coloumnsel  in  nBits  column index for op 10
- element  in  nBits  element data
- row  in  nBits*N  row data, entry j at [nBits*N-1-j*nBits -: nBits]
- coloumn  in  nBits*M  column data, entry i at [nBits*M-1-i*nBits -: nBits]
- stream_in  in  nBits  serial element data
- stream_valid  in  1  stream_in valid this cycle
- matrix  out  nBits*M*N  registered matrix, A[i][j] at [M*N*nBits-1-(N*i+j)*nBits -: nBits]
- done  out  1  one-cycle pulse: a write completed
- err  out  1  one-cycle pulse: command rejected for an out-of-range index

Behaviour:
- Reset values: matrix=0, ready=1, done=0, err=0, state IDLE, stream counters r=0, c=0.
- States: IDLE and LOAD.
- A command is accepted on a clock edge where valid and ready are both 1 and the state is IDLE.
- Op 00: if ipos<M and jpos<N, A[ipos][jpos] takes element. The new matrix is visible and done=1 in the cycle after acceptance.
- Op 01: if rowsel<M, every A[rowsel][j] takes row entry j. Timing as op 00.
- Op 10: if coloumnsel<N, every A[i][coloumnsel] takes coloumn entry i. Timing as op 00.
- Range violation on ops 00/01/10: matrix is unchanged, err=1 for one cycle (same timing as done), done stays 0. Indices are compared unsigned at full nBits width.
- For single writes ready stays 1, so back-to-back commands are accepted every cycle.
- Op 11: go to LOAD with r=c=0. ready=0 from the next cycle.
- In LOAD, each cycle with stream_valid=1:
  - A[r][c] takes stream_in.
  - c increments; when c wraps from N-1 to 0, r increments.
  - stream_valid=0 stalls with no change.
- On the M*N-th accepted element: state returns to IDLE, r=c=0. done=1 and ready=1 in the following cycle.
- valid is ignored in LOAD. stream_valid is ignored in IDLE.
- clear has highest priority in either state:
  - zeroes matrix and the counters next edge, goes to IDLE, ready=1;
  - no done, no err;
  - a command or stream beat in the same cycle is dropped.
- rst asserted at any time, including mid-stream, forces reset values immediately. Partial stream contents are lost.
- done and err are never both 1.
- matrix changes only on an accepted write, clear, or rst.

Test Plan (M=2, N=3, nBits=8; matrix is 48 bits):
- Reset, then op 00, ipos=1, jpos=2, element=8'hAB -> next cycle matrix=48'h0000000000AB, done=1 for one cycle, err=0.
- From zero: op 01, rowsel=0, row=24'h112233, then next cycle op 10, coloumnsel=1, coloumn=16'h5566 -> matrix=48'h115533006600, two done pulses on consecutive cycles.
- Op 11, then stream 01..06 with stream_valid low for one cycle between 03 and 04 -> matrix=48'h010203040506, ready=0 throughout LOAD, done=1 one cycle after 06, ready=1 at the same time.
- Op 00 with ipos=2 (out of range), element=8'hFF on matrix 48'h010203040506 -> matrix unchanged, err=1 for one cycle, done=0. Repeat with coloumnsel=3 on op 10 -> same response.
- Op 11, stream 01,02,03, then assert rst asynchronously mid-cycle -> matrix=0 and ready=1 immediately. After release, stream_valid pulses are ignored and matrix stays 0.
- In LOAD after 2 beats, assert clear together with stream_valid=1, stream_in=8'h77 -> next cycle matrix=0, state IDLE, ready=1, no done. A following op 11 stream restarts at A[0][0].
